lfsr_checker: RTL and testbench

Receive-side companion to the parallel Galois LFSR generator. The block consumes the 4-bit-per-word pseudo-random stream, for example as it arrives from the FIFO read port. It aligns a local reference LFSR to that stream by bit-slipping, declares lock, then counts word and bit errors. It sits in the 200 MHz domain after the FIFO pop and drives status LEDs and error counters.

---
 rtl/lfsr_checker_pkg.sv | 37 +++
 rtl/lfsr_checker_ref.sv | 50 +++++
 rtl/lfsr_checker.sv | 176 +++++++++++++++++
 tb/tb_lfsr_checker.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_checker_pkg.sv
// lfsr_checker_pkg: shared FSM type, default taps and the
// Galois LFSR stepping helper used by the PRBS checker.
package lfsr_checker_pkg;

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_e;

    localparam logic [7:0] DEFAULT_TAPS = 8'hB8;
    localparam int STEP_MAX_N = 8;

    typedef struct packed {
        logic [31:0] state;
        logic [7:0]  bits;
    } step_t;

    // Runs n Galois steps; bit i of .bits is the output of step i.
    function automatic step_t lfsr_step_n(
        input logic [31:0] state,
        input logic [31:0] taps,
        input int          n
    );
        step_t r;
        r.state = state;
        r.bits  = '0;
        for (int i = 0; i < STEP_MAX_N; i++) begin
            if (i < n) begin
                r.bits[i] = r.state[0];
                r.state   = (r.state >> 1) ^ (r.state[0] ? taps : 32'd0);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/lfsr_checker_ref.sv
// galois_lfsr_ref: local reference LFSR for the checker; offers the
// expected word and advances by one word or one word plus a bit slip.
module galois_lfsr_ref
    import lfsr_checker_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] SEED  = {{(WIDTH-1){1'b0}}, 1'b1},
    parameter logic [WIDTH-1:0] TAPS  = DEFAULT_TAPS,
    parameter int               BITS  = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic            advance,
    input  logic            slip,
    output logic [BITS-1:0] exp_word
);

    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] state_d;
    step_t            step_word;
    step_t            step_slip;
    logic             unused_step;

    always_comb begin
        step_word = lfsr_step_n(32'(state_q), 32'(TAPS), BITS);
        step_slip = lfsr_step_n(32'(state_q), 32'(TAPS), BITS + 1);
        exp_word  = step_word.bits[BITS-1:0];
        state_d   = state_q;
        if (load) begin
            state_d = SEED;
        end else if (slip) begin
            state_d = step_slip.state[WIDTH-1:0];
        end else if (advance) begin
            state_d = step_word.state[WIDTH-1:0];
        end
    end

    assign unused_step = ^{step_word.state[31:WIDTH], step_word.bits[7:BITS],
                           step_slip.state[31:WIDTH], step_slip.bits};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: rtl/lfsr_checker.sv
// lfsr_checker: aligns a reference LFSR to the received PRBS stream,
// declares lock and keeps saturating word/bit error counters.
module lfsr_checker
    import lfsr_checker_pkg::*;
#(
    parameter int                    LFSR_WIDTH = 8,
    parameter logic [LFSR_WIDTH-1:0] LFSR_SEED  = {{(LFSR_WIDTH-1){1'b0}}, 1'b1},
    parameter logic [LFSR_WIDTH-1:0] LFSR_TAPS  = DEFAULT_TAPS,
    parameter int                    LFSR_OUTPUT_BITS_PER_CLOCK = 4,
    parameter int                    LOCK_COUNT    = 4,
    parameter int                    UNLOCK_ERRORS = 3,
    parameter int                    CNT_WIDTH     = 16
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  resync,
    input  logic                                  clear_counts,
    input  logic                                  data_valid,
    input  logic [LFSR_OUTPUT_BITS_PER_CLOCK-1:0] data_in,
    output logic                                  locked,
    output logic                                  err_pulse,
    output logic [CNT_WIDTH-1:0]                  word_count,
    output logic [CNT_WIDTH-1:0]                  err_word_count,
    output logic [CNT_WIDTH-1:0]                  err_bit_count
);

    localparam int BITS = LFSR_OUTPUT_BITS_PER_CLOCK;
    localparam int MW   = $clog2(LOCK_COUNT + 1);
    localparam int UW   = $clog2(UNLOCK_ERRORS + 1);
    localparam logic [MW-1:0] LOCK_N   = MW'(LOCK_COUNT);
    localparam logic [UW-1:0] UNLOCK_N = UW'(UNLOCK_ERRORS);

    state_e               state_q, state_d;
    logic [MW-1:0]        match_cnt_q, match_cnt_d;
    logic [UW-1:0]        miss_cnt_q, miss_cnt_d;
    logic                 locked_q, locked_d;
    logic                 err_pulse_q, err_pulse_d;
    logic [CNT_WIDTH-1:0] word_cnt_q, word_cnt_d;
    logic [CNT_WIDTH-1:0] err_word_q, err_word_d;
    logic [CNT_WIDTH-1:0] err_bit_q, err_bit_d;
    logic [BITS-1:0]      exp_word;
    logic [BITS-1:0]      diff;
    logic [CNT_WIDTH-1:0] bit_errs;
    logic                 mismatch;
    logic                 advance;
    logic                 slip;
    logic                 count_en;

    galois_lfsr_ref #(
        .WIDTH (LFSR_WIDTH),
        .SEED  (LFSR_SEED),
        .TAPS  (LFSR_TAPS),
        .BITS  (BITS)
    ) u_ref (
        .clk      (clk),
        .reset    (reset),
        .load     (resync),
        .advance  (advance),
        .slip     (slip),
        .exp_word (exp_word)
    );

    function automatic logic [CNT_WIDTH-1:0] sat_add(
        input logic [CNT_WIDTH-1:0] a,
        input logic [CNT_WIDTH-1:0] b
    );
        logic [CNT_WIDTH:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[CNT_WIDTH] ? '1 : s[CNT_WIDTH-1:0];
    endfunction

    assign diff     = data_in ^ exp_word;
    assign mismatch = |diff;
    assign bit_errs = CNT_WIDTH'($countones(diff));

    always_comb begin
        state_d     = state_q;
        match_cnt_d = match_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        advance     = 1'b0;
        slip        = 1'b0;
        count_en    = 1'b0;
        if (resync) begin
            state_d     = ST_HUNT;
            match_cnt_d = '0;
            miss_cnt_d  = '0;
        end else if (data_valid) begin
            unique case (state_q)
                ST_HUNT: begin
                    if (mismatch) begin
                        slip = 1'b1;
                    end else begin
                        advance     = 1'b1;
                        match_cnt_d = MW'(1);
                        state_d     = (match_cnt_d == LOCK_N) ? ST_LOCKED : ST_VERIFY;
                    end
                end
                ST_VERIFY: begin
                    if (mismatch) begin
                        slip        = 1'b1;
                        state_d     = ST_HUNT;
                        match_cnt_d = '0;
                    end else begin
                        advance     = 1'b1;
                        match_cnt_d = match_cnt_q + 1'b1;
                        if (match_cnt_d == LOCK_N) state_d = ST_LOCKED;
                    end
                end
                ST_LOCKED: begin
                    // Dropping lock keeps the phase: no slip on this word.
                    advance  = 1'b1;
                    count_en = 1'b1;
                    if (mismatch) begin
                        miss_cnt_d = miss_cnt_q + 1'b1;
                        if (miss_cnt_d == UNLOCK_N) begin
                            state_d     = ST_HUNT;
                            miss_cnt_d  = '0;
                            match_cnt_d = '0;
                        end
                    end else begin
                        miss_cnt_d = '0;
                    end
                end
                default: state_d = ST_HUNT;
            endcase
        end
    end

    always_comb begin
        word_cnt_d  = word_cnt_q;
        err_word_d  = err_word_q;
        err_bit_d   = err_bit_q;
        err_pulse_d = count_en & mismatch;
        locked_d    = (state_d == ST_LOCKED);
        if (clear_counts) begin
            word_cnt_d = '0;
            err_word_d = '0;
            err_bit_d  = '0;
        end else if (count_en) begin
            word_cnt_d = sat_add(word_cnt_q, CNT_WIDTH'(1));
            if (mismatch) begin
                err_word_d = sat_add(err_word_q, CNT_WIDTH'(1));
                err_bit_d  = sat_add(err_bit_q, bit_errs);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_HUNT;
            match_cnt_q <= '0;
            miss_cnt_q  <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            word_cnt_q  <= '0;
            err_word_q  <= '0;
            err_bit_q   <= '0;
        end else begin
            state_q     <= state_d;
            match_cnt_q <= match_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            locked_q    <= locked_d;
            err_pulse_q <= err_pulse_d;
            word_cnt_q  <= word_cnt_d;
            err_word_q  <= err_word_d;
            err_bit_q   <= err_bit_d;
        end
    end

    assign locked         = locked_q;
    assign err_pulse      = err_pulse_q;
    assign word_count     = word_cnt_q;
    assign err_word_count = err_word_q;
    assign err_bit_count  = err_bit_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Testbench for lfsr_checker: behavioural model fills a scoreboard per
// driven word; outputs are popped and compared one clock later.
module tb_lfsr_checker;

    localparam int CW = 8;
    localparam int CMAXI = 255;
    localparam logic [CW-1:0] CMAX = '1;

    logic          clk = 1'b0;
    logic          reset;
    logic          resync;
    logic          clear_counts;
    logic          data_valid;
    logic [3:0]    data_in;
    logic          locked;
    logic          err_pulse;
    logic [CW-1:0] word_count;
    logic [CW-1:0] err_word_count;
    logic [CW-1:0] err_bit_count;

    always #5 clk = ~clk;

    // Narrow counters so saturation is reachable in a short run.
    lfsr_checker #(.CNT_WIDTH(CW)) dut (
        .clk            (clk),
        .reset          (reset),
        .resync         (resync),
        .clear_counts   (clear_counts),
        .data_valid     (data_valid),
        .data_in        (data_in),
        .locked         (locked),
        .err_pulse      (err_pulse),
        .word_count     (word_count),
        .err_word_count (err_word_count),
        .err_bit_count  (err_bit_count)
    );

    typedef struct {
        bit            lk;
        bit            ep;
        logic [CW-1:0] wc;
        logic [CW-1:0] ewc;
        logic [CW-1:0] ebc;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    logic [7:0]    m_ref;
    int            m_st;
    int            m_match;
    int            m_miss;
    logic [CW-1:0] m_wc, m_ewc, m_ebc;
    logic [7:0]    g;

    function automatic logic [7:0] step1(input logic [7:0] s);
        return s[0] ? ((s >> 1) ^ 8'hB8) : (s >> 1);
    endfunction

    function automatic logic [7:0] adv(input logic [7:0] s, input int n);
        logic [7:0] t;
        t = s;
        for (int i = 0; i < n; i++) t = step1(t);
        return t;
    endfunction

    function automatic logic [3:0] peek_word(input logic [7:0] s);
        logic [3:0] w;
        logic [7:0] t;
        t = s;
        for (int i = 0; i < 4; i++) begin
            w[i] = t[0];
            t    = step1(t);
        end
        return w;
    endfunction

    function automatic logic [3:0] gen_word();
        logic [3:0] w;
        w = peek_word(g);
        g = adv(g, 4);
        return w;
    endfunction

    function automatic logic [CW-1:0] sat(input int v);
        return (v > CMAXI) ? CMAX : CW'(v);
    endfunction

    task automatic model(input bit rst, input bit rs, input bit clr,
                         input bit v, input logic [3:0] d, output exp_t e);
        logic [3:0] w;
        bit         miss;
        int         nb;
        e.ep = 1'b0;
        if (rst) begin
            m_ref = 8'h01; m_st = 0; m_match = 0; m_miss = 0;
            m_wc = '0; m_ewc = '0; m_ebc = '0;
        end else begin
            if (rs) begin
                m_ref = 8'h01; m_st = 0; m_match = 0; m_miss = 0;
            end else if (v) begin
                w    = peek_word(m_ref);
                miss = (w != d);
                nb   = $countones(w ^ d);
                if (m_st == 2) begin
                    m_ref = adv(m_ref, 4);
                    if (!clr) begin
                        m_wc = sat(int'(m_wc) + 1);
                        if (miss) begin
                            m_ewc = sat(int'(m_ewc) + 1);
                            m_ebc = sat(int'(m_ebc) + nb);
                        end
                    end
                    if (miss) begin
                        e.ep = 1'b1;
                        m_miss++;
                        if (m_miss == 3) begin
                            m_st = 0; m_miss = 0; m_match = 0;
                        end
                    end else begin
                        m_miss = 0;
                    end
                end else if (miss) begin
                    m_ref = adv(m_ref, 5); m_st = 0; m_match = 0;
                end else begin
                    m_ref = adv(m_ref, 4);
                    m_match++;
                    m_st = (m_match == 4) ? 2 : 1;
                end
            end
            if (clr) begin
                m_wc = '0; m_ewc = '0; m_ebc = '0;
            end
        end
        e.lk  = (m_st == 2);
        e.wc  = m_wc;
        e.ewc = m_ewc;
        e.ebc = m_ebc;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_out();
        exp_t e;
        e = sb.pop_front();
        chk("locked", 32'(locked), 32'(e.lk));
        chk("err_pulse", 32'(err_pulse), 32'(e.ep));
        chk("word_count", 32'(word_count), 32'(e.wc));
        chk("err_word_count", 32'(err_word_count), 32'(e.ewc));
        chk("err_bit_count", 32'(err_bit_count), 32'(e.ebc));
    endtask

    task automatic cyc(input bit rst, input bit rs, input bit clr,
                       input bit v, input logic [3:0] d);
        exp_t e;
        reset        = rst;
        resync       = rs;
        clear_counts = clr;
        data_valid   = v;
        data_in      = d;
        model(rst, rs, clr, v, d, e);
        sb.push_back(e);
        @(posedge clk);
        #1;
        check_out();
    endtask

    task automatic word(input logic [3:0] d);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, d);
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'($urandom_range(15)));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not finish, observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; resync = 1'b0; clear_counts = 1'b0;
        data_valid = 1'b0; data_in = '0;
        g = 8'h01;

        cyc(1'b1, 1'b0, 1'b0, 1'b1, 4'hA);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 4'h5);
        chk("rst_locked", 32'(locked), 0);
        chk("rst_err_pulse", 32'(err_pulse), 0);
        chk("rst_word_count", 32'(word_count), 0);

        // Aligned stream from seed.
        g = 8'h01;
        for (int i = 0; i < 4; i++) begin
            word(gen_word());
            if (i == 2) chk("pre_lock", 32'(locked), 0);
        end
        chk("lock_after_4", 32'(locked), 1);
        for (int i = 0; i < 96; i++) begin
            word(gen_word());
            if (i % 10 == 3) idle();
        end
        chk("t1_err_words", 32'(err_word_count), 0);
        chk("t1_err_bits", 32'(err_bit_count), 0);

        // Stream with first word dropped: hunt must slip into alignment.
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
        chk("resync_unlock", 32'(locked), 0);
        g = 8'h01;
        void'(gen_word());
        for (int i = 0; i < 600 && m_st != 2; i++) word(gen_word());
        chk("t2_locked", 32'(locked), 1);
        for (int i = 0; i < 20; i++) word(gen_word());
        chk("t2_err_words", 32'(err_word_count), 0);

        // Single corrupted word.
        word(gen_word() ^ 4'hF);
        chk("t3_pulse", 32'(err_pulse), 1);
        chk("t3_err_words", 32'(err_word_count), 1);
        chk("t3_err_bits", 32'(err_bit_count), 4);
        chk("t3_locked", 32'(locked), 1);
        word(gen_word());
        chk("t3_pulse_end", 32'(err_pulse), 0);

        // Three consecutive corrupted words drop lock.
        word(gen_word() ^ 4'h1);
        word(gen_word() ^ 4'h3);
        chk("t4_still_locked", 32'(locked), 1);
        word(gen_word() ^ 4'hF);
        chk("t4_unlocked", 32'(locked), 0);
        chk("t4_err_words", 32'(err_word_count), 4);
        chk("t4_err_bits", 32'(err_bit_count), 11);
        for (int i = 0; i < 600 && m_st != 2; i++) word(gen_word());
        chk("t4_relock", 32'(locked), 1);

        // Drive error counters into saturation.
        for (int i = 0; i < 200 && m_ewc != CMAX; i++) begin
            word(gen_word() ^ 4'hF);
            word(gen_word() ^ 4'h6);
            word(gen_word());
        end
        chk("t5_ewc_sat", 32'(err_word_count), 32'(CMAX));
        chk("t5_ebc_sat", 32'(err_bit_count), 32'(CMAX));
        word(gen_word() ^ 4'hF);
        chk("t5_ewc_hold", 32'(err_word_count), 32'(CMAX));
        chk("t5_ebc_hold", 32'(err_bit_count), 32'(CMAX));
        word(gen_word());
        cyc(1'b0, 1'b0, 1'b1, 1'b1, gen_word() ^ 4'h9);
        chk("t5_clr_pulse", 32'(err_pulse), 1);
        chk("t5_clr_ewc", 32'(err_word_count), 0);
        chk("t5_clr_ebc", 32'(err_bit_count), 0);
        chk("t5_clr_wc", 32'(word_count), 0);
        word(gen_word() ^ 4'h1);
        chk("t5_post_ewc", 32'(err_word_count), 1);
        chk("t5_post_ebc", 32'(err_bit_count), 1);
        word(gen_word());

        // Resync while locked, with valid gaps, then restart from seed.
        cyc(1'b0, 1'b1, 1'b0, 1'b1, gen_word());
        chk("t6_unlock", 32'(locked), 0);
        chk("t6_no_pulse", 32'(err_pulse), 0);
        idle(); idle(); idle();
        g = 8'h01;
        word(gen_word()); idle();
        word(gen_word()); word(gen_word()); idle();
        chk("t6_not_yet", 32'(locked), 0);
        word(gen_word());
        chk("t6_relock", 32'(locked), 1);
        chk("t6_ewc_kept", 32'(err_word_count), 1);
        chk("t6_ebc_kept", 32'(err_bit_count), 1);
        for (int i = 0; i < 8; i++) word(gen_word());

        // Reset mid-stream, then the seed word is expected again.
        cyc(1'b1, 1'b0, 1'b0, 1'b1, gen_word() ^ 4'hF);
        chk("t7_locked", 32'(locked), 0);
        chk("t7_wc", 32'(word_count), 0);
        chk("t7_ewc", 32'(err_word_count), 0);
        g = 8'h01;
        for (int i = 0; i < 6; i++) word(gen_word());
        chk("t7_relock", 32'(locked), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
